// File: rtl/bit_serializer.sv
// Parallel-in/serial-out stage: accepts WIDTH-bit words over valid/ready and
// emits one bit per clock on dout_o, qualified by valid_o, with consumer stalls.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    input  logic             stall_i,
    output logic             dout_o,
    output logic             valid_o,
    output logic             busy_o,
    output logic             frame_done_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    logic shifting;
    logic last;
    logic accept;
    logic [WIDTH-1:0] shreg_next;

    // Outputs are gated by rst_i so they read as 0 during the reset cycle itself.
    always_comb begin
        shifting     = (state == SHIFT);
        last         = (cnt == LAST_IDX);
        busy_o       = shifting & ~rst_i;
        valid_o      = shifting & ~stall_i & ~rst_i;
        frame_done_o = valid_o & last;
        data_ready_o = ~rst_i & (~shifting | (valid_o & last));
        dout_o       = ~rst_i & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
        accept       = data_valid_i & data_ready_o;
        shreg_next   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, shreg[WIDTH-1:1]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            shreg <= '0;
            cnt   <= '0;
        end else if (accept) begin
            state <= SHIFT;
            shreg <= data_i;
            cnt   <= '0;
        end else if (shifting && !stall_i) begin
            if (last) begin
                state <= IDLE;
            end else begin
                shreg <= shreg_next;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule
